control_pipeline: RTL and testbench

- Next-generation control unit for the 16-opcode pipelined core: decodes opcodeD and carries the control bundle through the E, M and WB pipeline registers.
- Each stage has a valid bit.
- Adds a multi-cycle MUL sequencer, an external stall and a branch flush.
- Sits between the decode stage and the datapath; replaces the purely combinational decoder.

---
 rtl/control_pkg.sv | 37 +++
 rtl/control_decoder.sv | 31 +++
 rtl/control_pipeline.sv | 137 +++++++++++++
 tb/tb_control_pipeline.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared opcode, ALU, branch, control-bundle and MUL FSM types for control_pipeline.
package control_pkg;

    typedef enum logic [3:0] {
        OP_NOP, OP_STORE, OP_MOVI, OP_MOV, OP_OUT, OP_ADD, OP_SUB, OP_LOAD,
        OP_AND, OP_SHR, OP_CMP, OP_BEQ, OP_JR, OP_BGT, OP_MUL, OP_JMP
    } opcode_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_PASSA = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b101;
    localparam logic [2:0] ALU_MUL   = 3'b110;
    localparam logic [2:0] ALU_SHIFT = 3'b111;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_EQ     = 3'd1,
        BR_GT     = 3'd2,
        BR_UNCOND = 3'd3,
        BR_REG    = 3'd4
    } branch_type_e;

    typedef struct packed {
        logic         we;
        logic         d2sel;
        logic [2:0]   alu;
        logic         mwe;
        logic         rsel;
        logic         out;
        branch_type_e br;
    } ctrl_bundle_t;

    typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_e;

endpackage

// File: rtl/control_decoder.sv
// control_decoder: combinational opcode to control-bundle table; unlisted fields stay 0.
module control_decoder
    import control_pkg::*;
(
    input  opcode_e      opcode_i,
    output ctrl_bundle_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_STORE: begin ctrl_o.alu = ALU_PASSA; ctrl_o.mwe = 1'b1; end
            OP_MOVI:  begin ctrl_o.we = 1'b1; ctrl_o.d2sel = 1'b1; ctrl_o.alu = ALU_PASSB; end
            OP_MOV:   begin ctrl_o.we = 1'b1; ctrl_o.alu = ALU_PASSA; end
            OP_OUT:   begin ctrl_o.alu = ALU_PASSA; ctrl_o.out = 1'b1; end
            OP_ADD:   begin ctrl_o.we = 1'b1; ctrl_o.alu = ALU_ADD; end
            OP_SUB:   begin ctrl_o.we = 1'b1; ctrl_o.alu = ALU_SUB; end
            OP_LOAD:  begin ctrl_o.we = 1'b1; ctrl_o.alu = ALU_PASSA; ctrl_o.rsel = 1'b1; end
            OP_AND:   begin ctrl_o.we = 1'b1; ctrl_o.alu = ALU_AND; end
            OP_SHR:   begin ctrl_o.we = 1'b1; ctrl_o.alu = ALU_SHIFT; end
            OP_CMP:   ctrl_o.alu = ALU_SUB;
            OP_BEQ:   begin ctrl_o.d2sel = 1'b1; ctrl_o.alu = ALU_PASSB; ctrl_o.br = BR_EQ; end
            OP_JR:    begin ctrl_o.alu = ALU_PASSA; ctrl_o.br = BR_REG; end
            OP_BGT:   begin ctrl_o.d2sel = 1'b1; ctrl_o.alu = ALU_PASSB; ctrl_o.br = BR_GT; end
            OP_MUL:   begin ctrl_o.we = 1'b1; ctrl_o.alu = ALU_MUL; end
            OP_JMP:   begin ctrl_o.d2sel = 1'b1; ctrl_o.alu = ALU_PASSB; ctrl_o.br = BR_UNCOND; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: decode plus E/M/WB control registers with MUL sequencer, external stall and branch flush.
// Define CONTROL_PIPELINE_PERF_EN to add the retiredCount/stallCount performance counters.
module control_pipeline
    import control_pkg::*;
#(
    parameter int OPCODEWIDTH  = 4,
    parameter int ALUCTRLWIDTH = 3,
    parameter int MUL_LATENCY  = 3
`ifdef CONTROL_PIPELINE_PERF_EN
    ,
    parameter int CNTWIDTH     = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODEWIDTH-1:0]  opcodeD,
    input  logic                    validD,
    input  logic                    stallExt,
    input  logic                    flushE,
    output logic                    stallD,
    output logic                    data2SelectorE,
    output logic [ALUCTRLWIDTH-1:0] aluControlE,
    output logic [2:0]              branchTypeE,
    output logic                    mulBusyE,
    output logic                    writeDataEnableM,
    output logic                    outFlagM,
    output logic                    writeEnableWB,
    output logic                    resultSelectorWB
`ifdef CONTROL_PIPELINE_PERF_EN
    ,
    output logic [CNTWIDTH-1:0]     retiredCount,
    output logic [CNTWIDTH-1:0]     stallCount
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);

    opcode_e      op_d;
    ctrl_bundle_t dec_ctrl;
    ctrl_bundle_t ctrl_e_q;
    logic         valid_e_q, valid_m_q, valid_wb_q;
    logic         mwe_m_q, out_m_q, we_m_q, rsel_m_q, we_wb_q, rsel_wb_q;
    mul_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         mul_hold;

    // Opcodes with any bit set above the low nibble are not part of the ISA.
    assign op_d = ((opcodeD >> 4) == '0) ? opcode_e'(opcodeD[3:0]) : OP_NOP;

    control_decoder u_decoder (
        .opcode_i (op_d),
        .ctrl_o   (dec_ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mul_hold = (state_q == MUL_IDLE && valid_e_q && ctrl_e_q.alu == ALU_MUL && MUL_LATENCY > 1)
                || (state_q == MUL_BUSY && cnt_q != 4'd0);
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (!stallExt) begin
            if (state_q == MUL_IDLE && mul_hold) begin
                state_d = MUL_BUSY;
                cnt_d   = CNT_INIT;
            end else if (state_q == MUL_BUSY) begin
                state_d = (cnt_q == 4'd0) ? MUL_IDLE : MUL_BUSY;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
        end
    end

    // Payload registers load unconditionally on advance; the valid bits alone decide visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_e_q   <= '0;
            valid_e_q  <= 1'b0;
            valid_m_q  <= 1'b0;
            valid_wb_q <= 1'b0;
            mwe_m_q    <= 1'b0;
            out_m_q    <= 1'b0;
            we_m_q     <= 1'b0;
            rsel_m_q   <= 1'b0;
            we_wb_q    <= 1'b0;
            rsel_wb_q  <= 1'b0;
        end else if (!stallExt) begin
            valid_wb_q <= valid_m_q;
            we_wb_q    <= we_m_q;
            rsel_wb_q  <= rsel_m_q;
            valid_m_q  <= valid_e_q && !mul_hold;
            mwe_m_q    <= ctrl_e_q.mwe;
            out_m_q    <= ctrl_e_q.out;
            we_m_q     <= ctrl_e_q.we;
            rsel_m_q   <= ctrl_e_q.rsel;
            if (!mul_hold) begin
                valid_e_q <= validD && !flushE;
                ctrl_e_q  <= dec_ctrl;
            end
        end
    end

    assign stallD           = stallExt | mul_hold;
    assign mulBusyE         = (state_q == MUL_BUSY) || mul_hold;
    assign data2SelectorE   = valid_e_q & ctrl_e_q.d2sel;
    assign aluControlE      = valid_e_q ? ALUCTRLWIDTH'(ctrl_e_q.alu) : '0;
    assign branchTypeE      = valid_e_q ? ctrl_e_q.br : BR_NONE;
    assign writeDataEnableM = valid_m_q & mwe_m_q;
    assign outFlagM         = valid_m_q & out_m_q;
    assign writeEnableWB    = valid_wb_q & we_wb_q;
    assign resultSelectorWB = valid_wb_q & rsel_wb_q;

`ifdef CONTROL_PIPELINE_PERF_EN
    logic [CNTWIDTH-1:0] retired_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            retired_q   <= (valid_wb_q && !stallExt) ? retired_q + CNTWIDTH'(1) : retired_q;
            stall_cnt_q <= stallD ? stall_cnt_q + CNTWIDTH'(1) : stall_cnt_q;
        end
    end

    assign retiredCount = retired_q;
    assign stallCount   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed vector table plus randomized run against a slot-level pipeline model.
module tb_control_pipeline;

    localparam int L = 3;

    logic       clk = 1'b0, rst = 1'b1, validD = 1'b0, stallExt = 1'b0, flushE = 1'b0;
    logic [3:0] opcodeD = 4'h0;
    logic       stallD, data2SelectorE, mulBusyE, writeDataEnableM, outFlagM, writeEnableWB, resultSelectorWB;
    logic [2:0] aluControlE, branchTypeE;
`ifdef CONTROL_PIPELINE_PERF_EN
    logic [31:0] retiredCount, stallCount;
`endif

    always #5 clk = ~clk;

    control_pipeline #(.OPCODEWIDTH(4), .ALUCTRLWIDTH(3), .MUL_LATENCY(L)) dut (
        .clk              (clk),
        .rst              (rst),
        .opcodeD          (opcodeD),
        .validD           (validD),
        .stallExt         (stallExt),
        .flushE           (flushE),
        .stallD           (stallD),
        .data2SelectorE   (data2SelectorE),
        .aluControlE      (aluControlE),
        .branchTypeE      (branchTypeE),
        .mulBusyE         (mulBusyE),
        .writeDataEnableM (writeDataEnableM),
        .outFlagM         (outFlagM),
        .writeEnableWB    (writeEnableWB),
        .resultSelectorWB (resultSelectorWB)
`ifdef CONTROL_PIPELINE_PERF_EN
        ,
        .retiredCount     (retiredCount),
        .stallCount       (stallCount)
`endif
    );

    typedef struct packed {
        logic       sd, d2;
        logic [2:0] alu, br;
        logic       mb, mwe, outf, we, rs;
    } out_t;

    typedef struct {
        logic       r, v;
        logic [3:0] op;
        logic       sx, fl;
        out_t       e;
    } vec_t;

    // Fields: we, d2sel, alu[2:0], mwe, rsel, out, br[2:0]
    localparam logic [10:0] DEC [16] = '{
        11'b0_0_000_0_0_0_000, 11'b0_0_010_1_0_0_000, 11'b1_1_011_0_0_0_000, 11'b1_0_010_0_0_0_000,
        11'b0_0_010_0_0_1_000, 11'b1_0_000_0_0_0_000, 11'b1_0_001_0_0_0_000, 11'b1_0_010_0_1_0_000,
        11'b1_0_101_0_0_0_000, 11'b1_0_111_0_0_0_000, 11'b0_0_001_0_0_0_000, 11'b0_1_011_0_0_0_001,
        11'b0_0_010_0_0_0_100, 11'b0_1_011_0_0_0_010, 11'b1_0_110_0_0_0_000, 11'b0_1_011_0_0_0_011
    };

    vec_t       tbl[$];
    int         checks = 0, failures = 0;
    logic       e_v = 1'b0, m_v = 1'b0, w_v = 1'b0;
    logic [3:0] e_op = 4'h0, m_op = 4'h0, w_op = 4'h0;
    int         age = 0;

    function automatic out_t o(input logic sd, d2, input logic [2:0] alu, br,
                               input logic mb, mwe, outf, we, rs);
        return '{sd: sd, d2: d2, alu: alu, br: br, mb: mb, mwe: mwe, outf: outf, we: we, rs: rs};
    endfunction

    function automatic vec_t mk(input logic r, v, input logic [3:0] op, input logic sx, fl, input out_t e);
        return '{r: r, v: v, op: op, sx: sx, fl: fl, e: e};
    endfunction

    function automatic logic model_hold();
        return e_v && e_op == 4'hE && L > 1 && age < L - 1;
    endfunction

    function automatic out_t model_out(input logic sx);
        out_t        r;
        logic [10:0] de, dm, dw;
        de = DEC[e_op];
        dm = DEC[m_op];
        dw = DEC[w_op];
        r = '0;
        r.sd = sx | model_hold();
        if (e_v) begin
            r.d2  = de[9];
            r.alu = de[8:6];
            r.br  = de[2:0];
            r.mb  = e_op == 4'hE && L > 1;
        end
        if (m_v) begin
            r.mwe  = dm[5];
            r.outf = dm[3];
        end
        if (w_v) begin
            r.we = dw[10];
            r.rs = dw[4];
        end
        return r;
    endfunction

    task automatic model_step(input logic r, v, input logic [3:0] op, input logic sx, fl);
        logic hold;
        hold = model_hold();
        if (r) begin
            e_v = 1'b0; m_v = 1'b0; w_v = 1'b0; age = 0;
        end else if (!sx) begin
            w_v  = m_v;
            w_op = m_op;
            if (hold) begin
                m_v = 1'b0;
                age++;
            end else begin
                m_v  = e_v;
                m_op = e_op;
                e_v  = v && !fl;
                e_op = op;
                age  = 0;
            end
        end
    endtask

    function automatic out_t actual();
        return '{sd: stallD, d2: data2SelectorE, alu: aluControlE, br: branchTypeE, mb: mulBusyE,
                 mwe: writeDataEnableM, outf: outFlagM, we: writeEnableWB, rs: resultSelectorWB};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t a;
        a = actual();
        checks++;
        if (a !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, a, exp);
        end
    endtask

    task automatic apply(input logic r, v, input logic [3:0] op, input logic sx, fl);
        @(negedge clk);
        rst = r; validD = v; opcodeD = op; stallExt = sx; flushE = fl;
        #1;
    endtask

    initial begin
        out_t z, alu2, we1, mulh, mulb;
        logic r, v, sx, fl;
        logic [3:0] op;
        z    = '0;
        alu2 = o(0, 0, 3'd2, 3'd0, 0, 0, 0, 0, 0);
        we1  = o(0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0);
        mulh = o(1, 0, 3'd6, 3'd0, 1, 0, 0, 0, 0);
        mulb = o(0, 0, 3'd6, 3'd0, 1, 0, 0, 0, 0);
        // ADD, LOAD, STORE back to back
        tbl.push_back(mk(1, 1, 4'h5, 0, 0, z));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, z));
        tbl.push_back(mk(0, 1, 4'h7, 0, 0, z));
        tbl.push_back(mk(0, 1, 4'h1, 0, 0, alu2));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, o(0, 0, 3'd2, 3'd0, 0, 0, 0, 1, 0)));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, o(0, 0, 3'd0, 3'd0, 0, 1, 0, 1, 1)));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        // MUL then ADD
        tbl.push_back(mk(0, 1, 4'hE, 0, 0, z));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, mulh));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, mulh));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, mulb));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, we1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, we1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        // BEQ with flush kills the following ADD
        tbl.push_back(mk(0, 1, 4'hB, 0, 0, z));
        tbl.push_back(mk(0, 1, 4'h5, 0, 1, o(0, 1, 3'd3, 3'd1, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        // flush together with stall: only the second edge flushes
        tbl.push_back(mk(0, 1, 4'h8, 0, 0, z));
        tbl.push_back(mk(0, 1, 4'h6, 1, 1, o(1, 0, 3'd5, 3'd0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 4'h6, 0, 1, o(0, 0, 3'd5, 3'd0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, we1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        // MUL with a two-cycle external stall in BUSY
        tbl.push_back(mk(0, 1, 4'hE, 0, 0, z));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, mulh));
        tbl.push_back(mk(0, 1, 4'h5, 1, 0, mulh));
        tbl.push_back(mk(0, 1, 4'h5, 1, 0, mulh));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, mulh));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, mulb));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, we1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, we1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        // reset while BUSY
        tbl.push_back(mk(0, 1, 4'hE, 0, 0, z));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, mulh));
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, mulh));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, z));

        repeat (2) @(posedge clk);
        model_step(1, 0, 4'h0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].sx, tbl[i].fl);
            check($sformatf("vec%0d", i), tbl[i].e);
`ifdef CONTROL_PIPELINE_PERF_EN
            if (i == tbl.size() - 2) begin
                checks++;
                if (retiredCount !== 32'd0 || stallCount !== 32'd0) begin
                    failures++;
                    $display("FAIL perf_reset retired=%0d stalls=%0d exp=0", retiredCount, stallCount);
                end
            end
`endif
            @(posedge clk);
            model_step(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].sx, tbl[i].fl);
        end

        for (int i = 0; i < 800; i++) begin
            r  = $urandom_range(99) == 0;
            v  = $urandom_range(9) < 8;
            op = 4'($urandom_range(15));
            if ($urandom_range(3) == 0) op = 4'hE;
            sx = $urandom_range(99) < 15;
            fl = $urandom_range(99) < 15;
            apply(r, v, op, sx, fl);
            check($sformatf("rand%0d", i), model_out(sx));
            @(posedge clk);
            model_step(r, v, op, sx, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
